// File: rtl/log_fifo_pkg.sv
// log_fifo_pkg: read-FSM state type and encoding shared by the log FIFO controller.
package log_fifo_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        VALID = ST_VALID
    } state_t;
endpackage

// File: rtl/log_fifo_ptr.sv
// log_fifo_ptr: AW+1-bit write/read pointers and occupancy counter of the log FIFO.
module log_fifo_ptr #(
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    output logic [AW:0] wr_ptr,
    output logic [AW:0] rd_ptr,
    output logic [AW:0] level,
    output logic [AW:0] level_nxt
);
    assign level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
            level  <= level_nxt;
        end
    end
endmodule

// File: rtl/log_fifo_ctrl.sv
// log_fifo_ctrl: single-clock FIFO controller around an external registered-read RAM.
// Define LOG_FIFO_DROP_ON_FULL_EN to drop words while full instead of backpressuring.
module log_fifo_ctrl
    import log_fifo_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_waddr,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          overflow
);
    state_t        state, state_nxt;
    logic          push, pop, full;
    logic [AW:0]   wr_ptr, rd_ptr, level_nxt;

    log_fifo_ptr #(.AW(AW)) u_ptr (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .level     (level),
        .level_nxt (level_nxt)
    );

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = out_valid & out_ready;
    assign ram_wr_en = push;
    assign ram_wdata = in_data;
    assign ram_waddr = wr_ptr[AW-1:0];
    assign ram_raddr = rd_ptr[AW-1:0];
    assign out_data  = ram_rdata;

`ifdef LOG_FIFO_DROP_ON_FULL_EN
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign in_ready = 1'b1;
    assign push     = reset_n & in_valid & (~full | pop);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (in_valid & ~push)
            overflow <= 1'b1;
    end
`else
    assign in_ready = ~full;
    assign push     = reset_n & in_valid & in_ready;
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (level != '0) ? FETCH : IDLE;
            FETCH:   state_nxt = VALID;
            VALID:   state_nxt = pop ? ((level_nxt != '0) ? FETCH : IDLE) : VALID;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == VALID);
    end
endmodule

// File: tb/tb_log_fifo_ctrl.sv
// tb_log_fifo_ctrl: directed bench with a queue-based reference model and behavioural RAM.
module tb_log_fifo_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_waddr;
    logic          ram_wr_en;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW:0]   level;
    logic          overflow;

    int passed = 0;
    int total = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] got[$];
    int            gap = 0;
    bit            movf = 1'b0;

    always #5 clk = ~clk;

    log_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram_wdata (ram_wdata),
        .ram_waddr (ram_waddr),
        .ram_wr_en (ram_wr_en),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: a word queue plus the number of cycles before the head may be shown.
    always @(negedge clk) begin
        bit ev, pop, push, full, was_empty;
        if (!reset_n) begin
            mq.delete();
            gap = 0;
            movf = 1'b0;
        end
        ev = (mq.size() != 0) && (gap == 0);
        full = (mq.size() == DEPTH);
        pop = ev && out_ready;
`ifdef LOG_FIFO_DROP_ON_FULL_EN
        push = reset_n && in_valid && (!full || pop);
        check("in_ready", int'(in_ready), 1);
`else
        push = reset_n && in_valid && !full;
        check("in_ready", int'(in_ready), int'(!full));
`endif
        check("level", int'(level), mq.size());
        check("out_valid", int'(out_valid), int'(ev));
        check("overflow", int'(overflow), int'(movf));
        check("ram_wr_en", int'(ram_wr_en), int'(push));
        if (ev) check("out_data", int'(out_data), int'(mq[0]));
        if (reset_n) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && !push) movf = 1'b1;
`ifndef LOG_FIFO_DROP_ON_FULL_EN
            movf = 1'b0;
`endif
            was_empty = (mq.size() == 0);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(in_data);
            if (pop && mq.size() != 0) gap = 1;
            else if (was_empty && push) gap = 2;
            else if (gap > 0) gap--;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check("wait_valid", int'(out_valid), 1);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (level != 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_done", int'(level), 0);
        out_ready = 1'b0;
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = DW'(base + i);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int idx, n;
        bit acc;
        step();
        step();
        check("rst_level", int'(level), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_wr_en", int'(ram_wr_en), 0);
        reset_n = 1'b1;
        step();

        // single word latency
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        check("t1_level_e0", int'(level), 1);
        check("t1_valid_e0", int'(out_valid), 0);
        step();
        check("t1_valid_e1", int'(out_valid), 0);
        step();
        check("t1_valid_e2", int'(out_valid), 1);
        check("t1_data_e2", int'(out_data), 'hA5);
        step();
        check("t1_level_pop", int'(level), 0);
        check("t1_valid_pop", int'(out_valid), 0);
        step();
        check("t1_idle", int'(out_valid), 0);
        out_ready = 1'b0;

        // fill to full, then drain in order
        fill(16, 0);
        check("t2_in_ready_full", int'(in_ready), 0);
        check("t2_level_full", int'(level), 16);
        got.delete();
        drain();
        check("t2_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("t2_order", int'(got[i]), i);

        // streaming across pointer wrap
        got.delete();
        out_ready = 1'b1;
        idx = 0;
        n = 0;
        while (idx < 40 && n < 400) begin
            in_valid = 1'b1;
            in_data = DW'(8'h40 + idx);
            acc = in_ready;
            step();
            if (acc) idx++;
            n++;
        end
        in_valid = 1'b0;
        check("t3_all_pushed", idx, 40);
        drain();
        check("t3_count", got.size(), 40);
        for (int i = 0; i < 40 && i < got.size(); i++) check("t3_order", int'(got[i]), 'h40 + i);

        // push with pop at full
        fill(16, 'h80);
        wait_valid();
        got.delete();
        in_valid = 1'b1;
        in_data = 8'hC0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`ifdef LOG_FIFO_DROP_ON_FULL_EN
        in_valid = 1'b0;
        check("t4_level_same", int'(level), 16);
`else
        check("t4_level_pop", int'(level), 15);
        check("t4_in_ready_rise", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("t4_level_refill", int'(level), 16);
`endif
        drain();
        check("t4_count", got.size(), 17);
        for (int i = 0; i < 17 && i < got.size(); i++)
            check("t4_order", int'(got[i]), (i < 16) ? 'h80 + i : 'hC0);

        // 17 words offered with no pop
        got.delete();
        fill(17, 'h20);
        check("t5_level", int'(level), 16);
`ifdef LOG_FIFO_DROP_ON_FULL_EN
        check("t5_overflow", int'(overflow), 1);
`else
        check("t5_overflow", int'(overflow), 0);
        check("t5_in_ready", int'(in_ready), 0);
`endif
        drain();
        check("t5_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("t5_order", int'(got[i]), 'h20 + i);

        // asynchronous reset while presenting a word
        fill(5, 'h50);
        wait_valid();
        check("t6_level_pre", int'(level), 5);
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        in_data = 8'hEE;
        reset_n = 1'b0;
        #1;
        check("t6_valid", int'(out_valid), 0);
        check("t6_level", int'(level), 0);
        check("t6_in_ready", int'(in_ready), 1);
        check("t6_wr_en", int'(ram_wr_en), 0);
        check("t6_overflow", int'(overflow), 0);
        step();
        step();
        check("t6_wr_en_hold", int'(ram_wr_en), 0);
        reset_n = 1'b1;
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        in_data = 8'h3C;
        step();
        in_valid = 1'b0;
        wait_valid();
        check("t6_after_data", int'(out_data), 'h3C);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/log_fifo_ctrl.md
# log_fifo_ctrl

Single-clock FIFO controller that wraps the logger's dual-port block RAM. It accepts log words from the capture stage over a valid/ready handshake and drives the RAM write port. It also drives the RAM read port, covering the RAM's one-cycle registered read latency, and presents words to the UART transmit stage over a second valid/ready handshake. Both RAM clocks are tied to `clk`.

## Interface
Parameters:
- `AW`, 8: RAM address width; capacity `2**AW` words.
- `DW`, 8: data word width.

Ports:
- `clk`  in  1: clock; also drives RAM `wclk` and `rclk`.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  DW: word from capture stage.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the controller can take the word this cycle.
- `ram_wdata`  out  DW: to RAM `data_in`; equals `in_data`.
- `ram_waddr`  out  AW: to RAM `addr_w`; `wr_ptr[AW-1:0]`.
- `ram_wr_en`  out  1: to RAM `wr_en`; `in_valid & in_ready`.
- `ram_raddr`  out  AW: to RAM `addr_r`; `rd_ptr[AW-1:0]`.
- `ram_rdata`  in  DW: from RAM `data_out`, registered one cycle after `ram_raddr`.
- `out_data`  out  DW: word to UART stage; equals `ram_rdata`.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: UART stage takes the word.
- `level`  out  AW+1: words held, including the word presented on the output.
- `overflow`  out  1: sticky flag; set when an input word is dropped.

## Operation
- `wr_ptr` and `rd_ptr` are AW+1 bits wide and wrap modulo `2**(AW+1)`. Low AW bits address the RAM.
- Push: `in_valid & in_ready`. Effects: `wr_ptr++`, `level++`.
- Pop: `out_valid & out_ready`. Effects: `rd_ptr++`, `level--`.
- If push and pop happen in the same cycle, both pointers advance and `level` is unchanged.
- `in_ready = (level != 2**AW)` in backpressure mode; see Configuration.
- Read FSM, 2-bit:
  - IDLE: `out_valid=0`. Go to FETCH if `level != 0`.
  - FETCH: `out_valid=0`. `ram_raddr` is stable and the RAM samples it at the end of this cycle. Go to VALID.
  - VALID: `out_valid=1`. On pop, go to FETCH if `level-1 != 0` (including a same-cycle push), else go to IDLE. Without a pop, stay in VALID.
- While the FSM is in VALID, `rd_ptr` is held and the RAM re-reads the same address each cycle. That slot is not freed until the pop, so `out_data` stays stable while `out_ready=0`.
- No write can target the slot at `rd_ptr` while that slot is counted in `level`. This rules out read/write address collisions.
- Reset values: state=IDLE, `wr_ptr=0`, `rd_ptr=0`, `level=0`, `overflow=0`, `out_valid=0`, `in_ready=1`, `ram_wr_en=0`.
- When `reset_n` is asserted mid-transfer, the FIFO contents are discarded and all registers return to their reset values immediately. RAM contents are not cleared.

## Timing
- Write-to-output latency: a push at edge E0 gives `level=1` after E0. The FSM moves IDLE→FETCH at E1 and FETCH→VALID at E2, so `out_valid` is first high in the cycle after E2.
- Output throughput: at most one word per 2 cycles. Each pop costs one FETCH cycle.
- Input throughput: one word per cycle while not full.
- Full boundary: `in_ready` falls in the cycle after the push that reaches `level=2**AW`. It rises in the cycle after a pop.
- `level`, `in_ready` and `overflow` are all registered or derived from registers. No combinational path exists from `out_ready` to `in_ready`.

## Configuration
- Macro `LOG_FIFO_DROP_ON_FULL_EN`.
- Defined:
  - `in_ready` is constantly 1.
  - While full, an input word with `in_valid=1` is dropped: no RAM write and no pointer change.
  - `overflow` is set and stays set until reset.
  - In the same cycle as a pop, a push is accepted and not dropped, because the full check is against `level` after the pop.
- Undefined: backpressure mode. `overflow` is tied to 0.

## Structure
- Package `log_fifo_pkg`: FSM state typedef (IDLE, FETCH, VALID) and the state encoding constants.
- Optional sub-module `log_fifo_ptr`: AW+1-bit pointer plus level counter. The FSM and handshake logic stay in the top module.
- The RAM is instantiated one level up, next to this block, and is not inside it.

## Test plan
- Single word, AW=4: push 0xA5 at edge E0 with `out_ready=1` → `out_valid` high after E2 with `out_data=0xA5`. After the pop, `level=0` and the FSM returns to IDLE.
- Fill to 16 words (0x00..0x0F) with `out_ready=0` → `in_ready=0` and `level=16`. Then drain with `out_ready=1` → the same order is returned and `level` ends at 0.
- Wrap-around: run 40 push/pop cycles of an incrementing pattern through AW=4 → no loss and no reordering across pointer wrap.
- Push and pop in the same cycle at `level=16` → `level` stays 16, and the accepted word appears after 15 more pops.
- With `LOG_FIFO_DROP_ON_FULL_EN` defined: push 17 words with no pop → word 17 is dropped and `overflow=1`. Draining returns only the first 16 words.
- Assert `reset_n=0` while in VALID with `level=5` → `out_valid=0`, `level=0` and `in_ready=1` immediately, with no further RAM writes.
